// File: rtl/leg_fetch_writeback.sv
// Fetch/decode/write-back sequencer for the 8-bit LEG core: four-byte fetch, one
// EX cycle driving operand Load strobes, one WB cycle driving Save strobes and the PC.
module leg_fetch_writeback #(
  parameter int NUM_REGS = 6,
  parameter int PC_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  output logic [7:0] prog_addr,
  output logic       prog_req,
  input  logic [7:0] prog_data,
  input  logic       prog_valid,
  output logic [7:0] opcode,
  output logic [7:0] arg1_load,
  output logic [7:0] arg2_load,
  output logic [7:0] arg1_imm,
  output logic [7:0] arg2_imm,
  input  logic [7:0] result,
  input  logic       cond_true,
  output logic [7:0] reg_save,
  output logic [7:0] save_value,
  output logic       instr_done
);

  typedef enum logic [2:0] {S_IDLE, S_F0, S_F1, S_F2, S_F3, S_EX, S_WB} state_t;

  localparam logic [2:0] CNT_ADDR = 3'(NUM_REGS);
  localparam logic [7:0] STEP     = 8'(PC_STEP);

  state_t     state, state_nxt;
  logic [7:0] pc, arg1_q, arg2_q, dest_q;
  logic       is_cond, dest_is_pc;

  function automatic logic [7:0] onehot(input logic [2:0] a);
    return 8'b1 << a;
  endfunction

  assign is_cond    = opcode[5];
  assign dest_is_pc = (dest_q[2:0] == CNT_ADDR);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (run)        state_nxt = S_F0;
      S_F0:   if (prog_valid) state_nxt = S_F1;
      S_F1:   if (prog_valid) state_nxt = S_F2;
      S_F2:   if (prog_valid) state_nxt = S_F3;
      S_F3:   if (prog_valid) state_nxt = S_EX;
      S_EX:                   state_nxt = S_WB;
      S_WB:                   state_nxt = S_IDLE;
      default:                state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    prog_req   = 1'b0;
    prog_addr  = pc;
    arg1_load  = '0;
    arg2_load  = '0;
    instr_done = 1'b0;
    unique case (state)
      S_F0: begin prog_req = 1'b1; prog_addr = pc;         end
      S_F1: begin prog_req = 1'b1; prog_addr = pc + 8'd1;  end
      S_F2: begin prog_req = 1'b1; prog_addr = pc + 8'd2;  end
      S_F3: begin prog_req = 1'b1; prog_addr = pc + 8'd3;  end
      S_EX: begin
        // Immediate operands suppress the register read on that bus.
        if (!opcode[7]) arg1_load = onehot(arg1_q[2:0]);
        if (!opcode[6]) arg2_load = onehot(arg2_q[2:0]);
      end
      S_WB:    instr_done = 1'b1;
      default: ;
    endcase
  end

  assign arg1_imm = arg1_q;
  assign arg2_imm = arg2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opcode <= '0;
      arg1_q <= '0;
      arg2_q <= '0;
      dest_q <= '0;
    end else if (prog_valid) begin
      unique case (state)
        S_F0:    opcode <= prog_data;
        S_F1:    arg1_q <= prog_data;
        S_F2:    arg2_q <= prog_data;
        S_F3:    dest_q <= prog_data;
        default: ;
      endcase
    end
  end

  // Save strobes are registered on the EX->WB edge so they are live for WB only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_save   <= '0;
      save_value <= '0;
    end else if (state == S_EX && !is_cond && !dest_is_pc) begin
      reg_save   <= onehot(dest_q[2:0]);
      save_value <= result;
    end else begin
      reg_save   <= '0;
      save_value <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else if (state == S_WB) begin
      if (is_cond)         pc <= cond_true ? dest_q : pc + STEP;
      else if (dest_is_pc) pc <= result;
      else                 pc <= pc + STEP;
    end
  end

endmodule

// File: tb/tb_leg_fetch_writeback.sv
// Directed bench for leg_fetch_writeback: byte memory model, hand-computed expectations.
module tb_leg_fetch_writeback;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [7:0] prog_addr, prog_data;
  logic       prog_req, prog_valid;
  logic [7:0] opcode, arg1_load, arg2_load, arg1_imm, arg2_imm;
  logic [7:0] result = 8'h00;
  logic       cond_true = 1'b0;
  logic [7:0] reg_save, save_value;
  logic       instr_done;
  logic       blk = 1'b0;
  logic [7:0] mem [256];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign prog_data  = mem[prog_addr];
  assign prog_valid = ~blk;

  leg_fetch_writeback dut (
    .clk(clk), .rst(rst), .run(run),
    .prog_addr(prog_addr), .prog_req(prog_req), .prog_data(prog_data), .prog_valid(prog_valid),
    .opcode(opcode), .arg1_load(arg1_load), .arg2_load(arg2_load),
    .arg1_imm(arg1_imm), .arg2_imm(arg2_imm),
    .result(result), .cond_true(cond_true),
    .reg_save(reg_save), .save_value(save_value), .instr_done(instr_done)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic load4(input logic [7:0] a, input logic [7:0] b0, b1, b2, b3);
    mem[a] = b0; mem[a + 8'd1] = b1; mem[a + 8'd2] = b2; mem[a + 8'd3] = b3;
  endtask

  // Launch one instruction from IDLE (caller sits just after a falling edge).
  task automatic exec(input string tag, input logic [7:0] base,
                      input logic [7:0] e_a1l, e_a2l, e_a1i, e_a2i, e_rs, e_sv, e_pc,
                      input int e_lat, input int n_stall);
    logic [7:0] a1l_h [24], a2l_h [24], a1i_h [24], a2i_h [24], rs_h [24], sv_h [24];
    int done_cnt, done_cyc, stray, ex, wb;
    done_cnt = 0; done_cyc = 0; stray = 0;
    run = 1'b1;
    for (int c = 1; c <= e_lat + 3; c++) begin
      @(negedge clk);
      if (c == 1) begin
        run = 1'b0;
        chk({tag, "/f0_addr"}, prog_addr, base);
      end
      if (n_stall > 0 && c >= 2 && c <= 2 + n_stall) begin
        chk({tag, "/stall_addr"}, prog_addr, base + 8'd1);
        chk({tag, "/stall_req"}, prog_req, 1'b1);
      end
      a1l_h[c] = arg1_load; a2l_h[c] = arg2_load;
      a1i_h[c] = arg1_imm;  a2i_h[c] = arg2_imm;
      rs_h[c]  = reg_save;  sv_h[c]  = save_value;
      if (instr_done) begin done_cnt++; done_cyc = c; end
      else if (reg_save != 8'h00) stray++;
      blk = (c >= 2 && c <= 1 + n_stall);
    end
    blk = 1'b0;
    wb = (done_cyc > 1) ? done_cyc : 2;
    ex = wb - 1;
    chk({tag, "/done_cnt"}, done_cnt, 1);
    chk({tag, "/latency"}, done_cyc, e_lat);
    chk({tag, "/arg1_load"}, a1l_h[ex], e_a1l);
    chk({tag, "/arg2_load"}, a2l_h[ex], e_a2l);
    chk({tag, "/imm"}, {a1i_h[ex], a2i_h[ex]}, {e_a1i, e_a2i});
    chk({tag, "/reg_save"}, rs_h[wb], e_rs);
    chk({tag, "/save_value"}, sv_h[wb], e_sv);
    chk({tag, "/stray_save"}, stray, 0);
    chk({tag, "/pc"}, prog_addr, e_pc);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    #1;
    chk("rst/prog_req", prog_req, 1'b0);
    chk("rst/prog_addr", prog_addr, 8'h00);
    chk("rst/outs", {opcode, arg1_load, arg2_load, reg_save, save_value}, 40'h0);
    chk("rst/done", instr_done, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    chk("idle/prog_req", prog_req, 1'b0);

    load4(8'h00, 8'h00, 8'h01, 8'h02, 8'h03);
    load4(8'h04, 8'hC0, 8'h11, 8'h22, 8'h00);
    load4(8'h08, 8'h20, 8'h00, 8'h01, 8'h40);
    load4(8'h40, 8'h20, 8'h00, 8'h01, 8'h80);
    load4(8'h44, 8'h00, 8'h00, 8'h00, 8'h06);
    load4(8'h80, 8'h00, 8'h03, 8'h0C, 8'hF7);
    load4(8'h84, 8'h20, 8'h00, 8'h00, 8'hFC);
    load4(8'hFC, 8'h00, 8'h05, 8'h0D, 8'h02);

    result = 8'h5A; cond_true = 1'b0;
    exec("basic",  8'h00, 8'h02, 8'h04, 8'h01, 8'h02, 8'h08, 8'h5A, 8'h04, 6, 0);
    exec("imm",    8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h01, 8'h5A, 8'h08, 6, 0);
    cond_true = 1'b1;
    exec("br_t",   8'h08, 8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 6, 0);
    cond_true = 1'b0;
    exec("br_nt",  8'h40, 8'h01, 8'h02, 8'h00, 8'h01, 8'h00, 8'h00, 8'h44, 6, 0);
    result = 8'h80;
    exec("pc_dst", 8'h44, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h80, 6, 0);
    result = 8'h33;
    exec("stall",  8'h80, 8'h08, 8'h10, 8'h03, 8'h0C, 8'h80, 8'h33, 8'h84, 9, 3);
    result = 8'h99; cond_true = 1'b1;
    exec("br_fc",  8'h84, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFC, 6, 0);
    result = 8'h11; cond_true = 1'b0;
    exec("wrap",   8'hFC, 8'h20, 8'h20, 8'h05, 8'h0D, 8'h04, 8'h11, 8'h00, 6, 0);

    // Walk PC back to 8, then abort an instruction in F2.
    result = 8'h5A;
    exec("basic2", 8'h00, 8'h02, 8'h04, 8'h01, 8'h02, 8'h08, 8'h5A, 8'h04, 6, 0);
    exec("imm2",   8'h04, 8'h00, 8'h00, 8'h11, 8'h22, 8'h01, 8'h5A, 8'h08, 6, 0);
    load4(8'h08, 8'hC0, 8'h07, 8'h09, 8'h01);
    run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("abort/f2_addr", prog_addr, 8'h0A);
    chk("abort/opcode_pre", opcode, 8'hC0);
    rst = 1'b0;
    #1;
    chk("abort/outs", {opcode, arg1_imm, arg1_load, arg2_load, reg_save, save_value}, 48'h0);
    chk("abort/prog", {prog_req, prog_addr, instr_done}, 10'h0);
    @(negedge clk);
    @(negedge clk);
    chk("abort/no_wb", {reg_save, instr_done}, 9'h0);
    rst = 1'b1; run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    chk("abort/restart_addr", prog_addr, 8'h00);
    chk("abort/restart_req", prog_req, 1'b1);
    repeat (8) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
